// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, default datapath width and the
// request bundle carried from a requester to the shared ALU.
package alu_pkg;

  localparam int XLEN = 32;

  // funct3 operation selects of the RV32I integer ALU
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      funct3;
    logic            shift_ctrl;
    logic            sub_ctrl;
  } alu_req_t;

  // What the ALU sees when nobody is granted: an ADD of two zeros
  localparam alu_req_t ALU_REQ_IDLE = '{
    a:          '0,
    b:          '0,
    funct3:     F3_ADD,
    shift_ctrl: 1'b0,
    sub_ctrl:   1'b0
  };

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// One requester port of the shared ALU: a request handshake carrying the
// operands and control, plus the response handshake returning the result.
// master = requester side, slave = arbiter side.
interface alu_share_arb_if #(
  parameter int XLEN = alu_pkg::XLEN
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic [2:0]      req_funct3;
  logic            req_shift_ctrl;
  logic            req_sub_ctrl;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_funct3, req_shift_ctrl, req_sub_ctrl,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_funct3, req_shift_ctrl, req_sub_ctrl,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter. The grant is combinational from the
// eligibility vector; the pointer names the port favoured on a tie and
// flips to the other port after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  output logic [1:0] grant
);

  logic rr_ptr_reg;

  // Lone eligible port always wins; on a tie the pointer decides
  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = rr_ptr_reg ? 2'b10 : 2'b01;
    end
  end

  // After granting port n, favour the other port; hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= 1'b0;
    end else if (grant[0]) begin
      rr_ptr_reg <= 1'b1;
    end else if (grant[1]) begin
      rr_ptr_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational RV32I ALU between two requesters
// (port 0 execute path, port 1 address/branch-compare path). One request
// per cycle is granted round-robin; its result is captured into that port's
// response register one cycle after acceptance.
// Optional build macro ALU_ARB_STATS_EN adds saturating grant/conflict
// counters on stat_grant0, stat_grant1 and stat_conflict.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_arb_if.slave   p0,
  alu_share_arb_if.slave   p1,
  output logic [XLEN-1:0]  alu_in1,
  output logic [XLEN-1:0]  alu_in2,
  output logic [2:0]       alu_funct3,
  output logic             alu_shift_ctrl,
  output logic             alu_sub_ctrl,
  input  logic [XLEN-1:0]  alu_result
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]      stat_grant0,
  output logic [31:0]      stat_grant1,
  output logic [31:0]      stat_conflict
`endif
);

  alu_req_t        req [2];
  alu_req_t        sel;
  logic [1:0]      req_valid;
  logic [1:0]      rsp_ready;
  logic [1:0]      slot_free;
  logic [1:0]      elig;
  logic [1:0]      grant;
  logic [1:0]      rsp_valid_reg;
  logic [XLEN-1:0] rsp_data_reg [2];

  // Gather both ports into indexable form so the slot logic can be replicated
  assign req[0] = '{a: p0.req_a, b: p0.req_b, funct3: p0.req_funct3,
                    shift_ctrl: p0.req_shift_ctrl, sub_ctrl: p0.req_sub_ctrl};
  assign req[1] = '{a: p1.req_a, b: p1.req_b, funct3: p1.req_funct3,
                    shift_ctrl: p1.req_shift_ctrl, sub_ctrl: p1.req_sub_ctrl};
  assign req_valid = {p1.req_valid, p0.req_valid};
  assign rsp_ready = {p1.rsp_ready, p0.rsp_ready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      // A full slot still accepts if its consumer drains it this cycle
      assign slot_free[gi] = ~rsp_valid_reg[gi] | rsp_ready[gi];
      assign elig[gi]      = req_valid[gi] & slot_free[gi];

      // Response slot: refill on grant (overwrites a draining result), else release on drain
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rsp_valid_reg[gi] <= 1'b0;
          rsp_data_reg[gi]  <= '0;
        end else if (grant[gi]) begin
          rsp_valid_reg[gi] <= 1'b1;
          rsp_data_reg[gi]  <= alu_result;
        end else if (rsp_ready[gi]) begin
          rsp_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .elig  (elig),
    .grant (grant)
  );

  // Steer the granted port's fields to the ALU; idle ADD of zeros otherwise
  always_comb begin
    sel = ALU_REQ_IDLE;
    if (grant[0]) begin
      sel = req[0];
    end else if (grant[1]) begin
      sel = req[1];
    end
  end

  assign alu_in1        = sel.a;
  assign alu_in2        = sel.b;
  assign alu_funct3     = sel.funct3;
  assign alu_shift_ctrl = sel.shift_ctrl;
  assign alu_sub_ctrl   = sel.sub_ctrl;

  assign p0.req_ready = grant[0];
  assign p1.req_ready = grant[1];
  assign p0.rsp_valid = rsp_valid_reg[0];
  assign p1.rsp_valid = rsp_valid_reg[1];
  assign p0.rsp_data  = rsp_data_reg[0];
  assign p1.rsp_data  = rsp_data_reg[1];

`ifdef ALU_ARB_STATS_EN
  // Saturating counts of grants per port and of two-way contention cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (grant[0]) stat_grant0   <= sat_inc(stat_grant0);
      if (grant[1]) stat_grant1   <= sat_inc(stat_grant1);
      if (&elig)    stat_conflict <= sat_inc(stat_conflict);
    end
  end
`endif

endmodule
